// File: rtl/moore_seq_det_pkg.sv
// Shared constants and elaboration-time helpers for moore_seq_det: state sizing
// and the KMP-style next-state function used to build the transition table.
package moore_seq_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 16;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 32;

  function automatic int unsigned state_w(int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic logic pat_bit(logic [15:0] pattern, int unsigned idx);
    logic [15:0] t;
    t = pattern >> idx;
    return t[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first `base` pattern bits, b).
  function automatic int unsigned next_state(logic [15:0] pattern, int unsigned pat_w,
                                             int unsigned s, logic b, logic overlap);
    int unsigned base;
    int unsigned len;
    int unsigned kmax;
    int unsigned result;
    int unsigned pos;
    logic        ok;
    logic        seq_b;
    base   = (s == pat_w && !overlap) ? 0 : s;
    len    = base + 1;
    kmax   = (len > pat_w) ? pat_w : len;
    result = 0;
    for (int unsigned k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < k; m++) begin
        pos = len - k + m;
        if (pos < base) seq_b = pat_bit(pattern, pat_w - 1 - pos);
        else            seq_b = b;
        if (pat_bit(pattern, pat_w - 1 - m) != seq_b) ok = 1'b0;
      end
      if (ok) result = k;
    end
    return result;
  endfunction

endpackage

// File: rtl/moore_seq_det_if.sv
// Serial-input bundle for moore_seq_det. Counter signals exist only when
// MOORE_SEQ_DET_CNT_EN is defined.
interface moore_seq_det_if #(
  parameter int CNT_W = 8
);
  logic en;
  logic clear;
  logic i;
  logic o;
`ifdef MOORE_SEQ_DET_CNT_EN
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, clear, i, input o, match_cnt, cnt_sat);
  modport slave  (input en, clear, i, output o, match_cnt, cnt_sat);
`else
  modport master (output en, clear, i, input o);
  modport slave  (input en, clear, i, output o);
`endif
endinterface

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; holds at all-ones.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = &cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            cnt <= '0;
    else if (clear)        cnt <= '0;
    else if (inc && !sat)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/moore_seq_det.sv
// Moore serial pattern detector (MSB first) driven by an elaborated transition
// table. Define MOORE_SEQ_DET_CNT_EN to add the saturating match counter.
module moore_seq_det #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  moore_seq_det_if.slave   bus
);
  import moore_seq_det_pkg::*;

  localparam int unsigned STATE_W = state_w(PAT_W);
  localparam int unsigned TBL_N   = 2 ** (STATE_W + 1);
  localparam logic [STATE_W-1:0] FULL = STATE_W'(PAT_W);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("moore_seq_det: PAT_W out of range 2..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("moore_seq_det: CNT_W out of range 1..32");
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [STATE_W-1:0] lookup;
  logic [STATE_W-1:0] trans [TBL_N];

  // Table indexed by {state, bit}; unreachable codes above PAT_W map to 0.
  for (genvar s = 0; s < 2 ** STATE_W; s++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      if (s <= PAT_W) begin : g_live
        localparam int unsigned NS = next_state(16'(PATTERN), PAT_W, s, b != 0, OVERLAP != 0);
        assign trans[s * 2 + b] = STATE_W'(NS);
      end else begin : g_dead
        assign trans[s * 2 + b] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= '0;
    else        state <= state_next;
  end

  always_comb begin
    lookup     = trans[{state, bus.i}];
    state_next = state;
    if (bus.clear)   state_next = '0;
    else if (bus.en) state_next = lookup;
  end

  assign bus.o = (state == FULL);

`ifdef MOORE_SEQ_DET_CNT_EN
  logic match_inc;
  assign match_inc = bus.en && !bus.clear && (lookup == FULL);

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (match_inc),
    .clear (bus.clear),
    .cnt   (bus.match_cnt),
    .sat   (bus.cnt_sat)
  );
`endif
endmodule

// File: tb/tb_moore_seq_det.sv
// Bench for moore_seq_det: four configurations driven in lockstep, checked against
// a sliding-window reference model, a hand-computed vector table and corner sequences.
module tb_moore_seq_det;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  moore_seq_det_if #(.CNT_W(8)) ia ();
  moore_seq_det_if #(.CNT_W(8)) ib ();
  moore_seq_det_if #(.CNT_W(2)) ic ();
  moore_seq_det_if #(.CNT_W(3)) id ();

  moore_seq_det #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8))
    u_a (.clk(clk), .n_rst(n_rst), .bus(ia));
  moore_seq_det #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8))
    u_b (.clk(clk), .n_rst(n_rst), .bus(ib));
  moore_seq_det #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2))
    u_c (.clk(clk), .n_rst(n_rst), .bus(ic));
  moore_seq_det #(.PAT_W(5), .PATTERN(5'b10010), .OVERLAP(1), .CNT_W(3))
    u_d (.clk(clk), .n_rst(n_rst), .bus(id));

  int unsigned W   [4] = '{4, 4, 2, 5};
  logic [15:0] PAT [4] = '{16'hD, 16'hD, 16'h3, 16'h12};
  int unsigned OV  [4] = '{1, 0, 1, 1};
  int unsigned CW  [4] = '{8, 8, 2, 3};

  logic        act_o   [4];
  logic [31:0] act_cnt [4];
  logic        act_sat [4];

  assign act_o[0] = ia.o;
  assign act_o[1] = ib.o;
  assign act_o[2] = ic.o;
  assign act_o[3] = id.o;
`ifdef MOORE_SEQ_DET_CNT_EN
  assign act_cnt[0] = 32'(ia.match_cnt);
  assign act_cnt[1] = 32'(ib.match_cnt);
  assign act_cnt[2] = 32'(ic.match_cnt);
  assign act_cnt[3] = 32'(id.match_cnt);
  assign act_sat[0] = ia.cnt_sat;
  assign act_sat[1] = ib.cnt_sat;
  assign act_sat[2] = ic.cnt_sat;
  assign act_sat[3] = id.cnt_sat;
`endif

  // Reference: bits seen since the last restart, matched as a sliding window.
  int unsigned hlen  [4];
  logic [15:0] hbits [4];
  logic        m_o   [4];
  int unsigned m_cnt [4];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      hlen[k] = 0; hbits[k] = '0; m_o[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_upd(input logic e, input logic c, input logic b);
    int unsigned mask;
    logic        m;
    for (int k = 0; k < 4; k++) begin
      mask = (32'd1 << W[k]) - 1;
      if (c) begin
        hlen[k] = 0; m_o[k] = 1'b0; m_cnt[k] = 0;
      end else if (e) begin
        hbits[k] = {hbits[k][14:0], b};
        if (hlen[k] < 16) hlen[k]++;
        m = (hlen[k] >= W[k]) && ((hbits[k] & 16'(mask)) == PAT[k]);
        m_o[k] = m;
        if (m) begin
          if (m_cnt[k] < (32'd1 << CW[k]) - 1) m_cnt[k]++;
          if (OV[k] == 0) hlen[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp_model(input string name);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s o[%0d]", name, k), act_o[k], m_o[k]);
`ifdef MOORE_SEQ_DET_CNT_EN
      chk($sformatf("%s cnt[%0d]", name, k), act_cnt[k], m_cnt[k]);
      chk($sformatf("%s sat[%0d]", name, k), act_sat[k],
          (m_cnt[k] == (32'd1 << CW[k]) - 1) ? 1 : 0);
`endif
    end
  endtask

  task automatic set_in(input logic e, input logic c, input logic b);
    ia.en = e; ia.clear = c; ia.i = b;
    ib.en = e; ib.clear = c; ib.i = b;
    ic.en = e; ic.clear = c; ic.i = b;
    id.en = e; id.clear = c; id.i = b;
  endtask

  task automatic step(input string name, input logic e, input logic c, input logic b);
    set_in(e, c, b);
    model_upd(e, c, b);
    @(posedge clk);
    #1;
    cmp_model(name);
  endtask

  // Called 1 time unit after an edge; reset pulse sits mid-cycle.
  task automatic async_reset(input string name);
    #3;
    n_rst = 1'b0;
    model_reset();
    #1;
    cmp_model(name);
    #1;
    n_rst = 1'b1;
  endtask

  typedef struct {
    logic        en, clr, i;
    logic        oa, ob, oc;
    int unsigned ca, cb, cc;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl = '{
      '{1,0,1, 0,0,0, 0,0,0}, '{1,0,1, 0,0,1, 0,0,1}, '{1,0,0, 0,0,0, 0,0,1},
      '{1,0,1, 1,1,0, 1,1,1}, '{1,0,1, 0,0,1, 1,1,2}, '{1,0,0, 0,0,0, 1,1,2},
      '{1,0,1, 1,0,0, 2,1,2}, '{1,1,0, 0,0,0, 0,0,0}, '{1,0,1, 0,0,0, 0,0,0},
      '{1,0,1, 0,0,1, 0,0,1}, '{0,0,0, 0,0,1, 0,0,1}, '{0,0,1, 0,0,1, 0,0,1},
      '{0,0,0, 0,0,1, 0,0,1}, '{1,0,0, 0,0,0, 0,0,1}, '{1,0,1, 1,1,0, 1,1,1},
      '{0,0,0, 1,1,0, 1,1,1}, '{1,0,1, 0,0,1, 1,1,2}, '{1,0,1, 0,0,1, 1,1,3},
      '{1,0,0, 0,0,0, 1,1,3}, '{1,1,1, 0,0,0, 0,0,0}
    };

    set_in(1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    cmp_model("reset");
    n_rst = 1'b1;

    // Overlap / non-overlap stream, enable gap, then clear on a completing bit.
    for (int r = 0; r < 20; r++) begin
      step($sformatf("tbl%0d", r), tbl[r].en, tbl[r].clr, tbl[r].i);
      chk($sformatf("tbl%0d o_a", r), act_o[0], tbl[r].oa);
      chk($sformatf("tbl%0d o_b", r), act_o[1], tbl[r].ob);
      chk($sformatf("tbl%0d o_c", r), act_o[2], tbl[r].oc);
`ifdef MOORE_SEQ_DET_CNT_EN
      chk($sformatf("tbl%0d cnt_a", r), act_cnt[0], tbl[r].ca);
      chk($sformatf("tbl%0d cnt_b", r), act_cnt[1], tbl[r].cb);
      chk($sformatf("tbl%0d cnt_c", r), act_cnt[2], tbl[r].cc);
`endif
    end

    // Reset in the middle of 1101: the next 1 must not complete a match.
    step("pre_rst", 1'b1, 1'b0, 1'b1);
    step("pre_rst", 1'b1, 1'b0, 1'b1);
    step("pre_rst", 1'b1, 1'b0, 1'b0);
    async_reset("mid_rst");
    chk("mid_rst o_a", act_o[0], 0);
`ifdef MOORE_SEQ_DET_CNT_EN
    chk("mid_rst cnt_c", act_cnt[2], 0);
`endif
    step("post_rst", 1'b1, 1'b0, 1'b1);
    chk("post_rst o_a", act_o[0], 0);

    // Eight 1s into the 2-bit all-ones detector with a 2-bit counter.
    async_reset("sat_rst");
    for (int n = 1; n <= 8; n++) begin
      step($sformatf("sat%0d", n), 1'b1, 1'b0, 1'b1);
      chk($sformatf("sat%0d o_c", n), act_o[2], (n >= 2) ? 1 : 0);
`ifdef MOORE_SEQ_DET_CNT_EN
      chk($sformatf("sat%0d cnt_c", n), act_cnt[2], (n - 1 > 3) ? 3 : n - 1);
      chk($sformatf("sat%0d sat_c", n), act_sat[2], (n >= 4) ? 1 : 0);
`endif
    end

    // Random traffic, biased toward enabled samples, with rare clears and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      step("rnd", ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/moore_seq_det.md
# moore_seq_det

Parametrised Moore-style serial pattern detector: a single-bit input stream is compared, MSB first, against a compile-time pattern of configurable length. A registered match flag is asserted for each complete occurrence. Overlapping or non-overlapping matching is selectable, and an optional saturating match counter can be compiled in. It is the general successor to the team's fixed 4-bit sequence detector and serves as the serial-input front end in the lab datapath.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits; legal range 2..16; elaboration error outside it.
- PATTERN, 4'b1101: pattern; bit PAT_W-1 is expected first.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each match.
- CNT_W, 8: match counter width; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- n_rst  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; `i` is consumed only when high.
- clear  in  1  synchronous clear of the state and the counter.
- i  in  1  serial data bit.
- o  out  1  match flag; Moore output, decoded from the state register only.
- match_cnt  out  CNT_W  saturating count of matches; present only with the counter macro.
- cnt_sat  out  1  high while match_cnt is all-ones; present only with the counter macro.

## Operation
- State S holds the number of pattern bits currently matched.
  - Range 0..PAT_W; STATE_W = $clog2(PAT_W+1).
  - o = (S == PAT_W).
- Next state when en=1 (KMP-style automaton):
  - Let the base be S, except when S==PAT_W and OVERLAP=0, where the base is 0.
  - S' = length of the longest prefix of PATTERN that is a suffix of (first `base` pattern bits followed by `i`).
  - With no such prefix, S' = 0.
- The transition table is computed at elaboration by a constant function. No runtime search.
- en=0: S is held, so o is held.
- clear=1: S <= 0 and counter <= 0, regardless of en. clear has priority over en.
- Counter:
  - Increments by 1 on every clock edge where en=1, clear=0 and S'==PAT_W.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat is combinational from match_cnt.
- Back-to-back matches:
  - With OVERLAP=1, o stays high on consecutive cycles whenever the pattern permits. Example: all-ones pattern with an all-ones stream.
  - With OVERLAP=0, the minimum gap is PAT_W-1 cycles of o low.

## Timing
- Reset (n_rst low, asynchronous, any time including mid-pattern): S=0, o=0, match_cnt=0, cnt_sat=0. Effective immediately; no clock needed.
- First edge after n_rst deasserts samples normally.
- Latency: the last pattern bit is sampled at edge N; o is high from just after edge N until at least edge N+1. match_cnt reflects that match after edge N as well.
- No combinational path from i, en or clear to o. All outputs are registered or decoded from registers.
- Simultaneous clear and completing bit: clear wins. No match is flagged and the count stays 0.

## Configuration
- MOORE_SEQ_DET_CNT_EN defined:
  - match counter instantiated;
  - match_cnt and cnt_sat ports present.
- Undefined:
  - counter logic and both ports removed;
  - CNT_W ignored;
  - o behaviour identical in both builds.

## Structure
- Package moore_seq_det_pkg:
  - state_w(pat_w) constant function;
  - next_state(pattern, pat_w, s, bit, overlap) constant function used to build the transition table;
  - range-check constants PAT_W_MIN=2, PAT_W_MAX=16.
- Top moore_seq_det:
  - state register;
  - transition-table lookup;
  - output decode.
- One sub-module, seq_match_counter:
  - saturating counter with inc and clear;
  - generated only under MOORE_SEQ_DET_CNT_EN.

## Test plan
- Reset mid-pattern: PATTERN=1101, feed 1,1,0 then pulse n_rst low between edges -> o=0, match_cnt=0 immediately; next 1 does not complete a match.
- Overlap: defaults, en=1, stream 1,1,0,1,1,0,1 -> o high after the 4th and 7th bits; match_cnt=2.
- Non-overlap: OVERLAP=0, same stream -> o high only after the 4th bit; match_cnt=1.
- Enable gating: insert en=0 for 3 cycles between bits 2 and 3 of 1101, with i toggling while gated -> match still flagged after the 4th enabled bit; o held during the gap.
- Clear collision: assert clear on the edge sampling the final 1 of 1101 -> o stays 0, match_cnt stays 0.
- Saturation: CNT_W=2, PATTERN=2'b11, OVERLAP=1, stream of eight 1s -> o high from the 2nd bit onward; match_cnt stops at 3 and cnt_sat=1. Repeat without MOORE_SEQ_DET_CNT_EN -> identical o trace, no counter ports.
